video_mnist_color_decode: RTL and testbench



---
 rtl/video_mnist_color_decode.sv | 212 +++++++++++++++++++++
 tb/tb_video_mnist_color_decode.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_mnist_color_decode.sv
// video_mnist_color_decode: recovers the MNIST class number (palette match) and run length from an RGB AXI4-Stream.
// Latency: 2 accepted beats (st0 palette match, st1 run counter); tdata/tuser/tlast are delayed unmodified.
// Backpressure: single global stall, s_axi4s_tready = m_axi4s_tready || !m_axi4s_tvalid; bubbles flow through.
// Build option: define VIDEO_MNIST_COLOR_DECODE_TOLERANCE_EN to match palette entries within +/-param_tol per channel.
module video_mnist_color_decode #(
    parameter int TUSER_WIDTH   = 1,
    parameter int TDATA_WIDTH   = 24,
    parameter int TNUMBER_WIDTH = 4,
    parameter int TCOUNT_WIDTH  = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [7:0]               param_tol,
    input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
    input  logic                     s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
    input  logic                     s_axi4s_tvalid,
    output logic                     s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
    output logic                     m_axi4s_tlast,
    output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
    output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
    output logic [TCOUNT_WIDTH-1:0]  m_axi4s_tcount,
    output logic                     m_axi4s_tvalid,
    input  logic                     m_axi4s_tready
);

    localparam logic [TNUMBER_WIDTH-1:0] NO_MATCH = TNUMBER_WIDTH'(15);
    localparam logic [TCOUNT_WIDTH-1:0]  CNT_MAX  = '1;
    localparam logic [TCOUNT_WIDTH-1:0]  CNT_ONE  = TCOUNT_WIDTH'(1);

    // Overlay palette, RGB packed as R[23:16] G[15:8] B[7:0].
    function automatic logic [23:0] palette(input int idx);
        case (idx)
            0:       return 24'h000000;
            1:       return 24'h800000;
            2:       return 24'hFF0000;
            3:       return 24'hFFB74C;
            4:       return 24'hFFFF00;
            5:       return 24'h008000;
            6:       return 24'h0000FF;
            7:       return 24'h800080;
            8:       return 24'h808080;
            default: return 24'hFFFFFF;
        endcase
    endfunction

`ifdef VIDEO_MNIST_COLOR_DECODE_TOLERANCE_EN
    // One channel is close enough when |a-b| <= tol, using a 9-bit signed difference.
    function automatic logic chan_ok(input logic [7:0] a, input logic [7:0] b, input logic [7:0] tol);
        logic signed [8:0] diff;
        logic        [8:0] mag;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
        return (mag <= {1'b0, tol});
    endfunction

    function automatic logic pal_hit(input logic [23:0] pix, input int idx, input logic [7:0] tol);
        logic [23:0] p;
        p = palette(idx);
        return chan_ok(pix[23:16], p[23:16], tol) &&
               chan_ok(pix[15:8],  p[15:8],  tol) &&
               chan_ok(pix[7:0],   p[7:0],   tol);
    endfunction
`else
    // Exact colour compare; the tolerance input has no effect in this build.
    function automatic logic pal_hit(input logic [23:0] pix, input int idx);
        return (pix == palette(idx));
    endfunction

    logic unused_tol;
    assign unused_tol = ^param_tol;
`endif

    // Stage 0 registers
    logic                     vld0_q,  vld0_d;
    logic [TUSER_WIDTH-1:0]   user0_q, user0_d;
    logic                     last0_q, last0_d;
    logic [TDATA_WIDTH-1:0]   data0_q, data0_d;
    logic [TNUMBER_WIDTH-1:0] num0_q,  num0_d;

    // Stage 1 registers
    logic                     vld1_q,  vld1_d;
    logic [TUSER_WIDTH-1:0]   user1_q, user1_d;
    logic                     last1_q, last1_d;
    logic [TDATA_WIDTH-1:0]   data1_q, data1_d;
    logic [TNUMBER_WIDTH-1:0] num1_q,  num1_d;
    logic [TCOUNT_WIDTH-1:0]  cnt1_q,  cnt1_d;

    // Run state: last number seen, current run length, previous beat ended a line, any beat seen since reset
    logic [TNUMBER_WIDTH-1:0] last_num_q, last_num_d;
    logic [TCOUNT_WIDTH-1:0]  run_cnt_q,  run_cnt_d;
    logic                     prev_last_q, prev_last_d;
    logic                     seen_q,     seen_d;

    logic                     adv;
    logic                     line_start;
    logic [TNUMBER_WIDTH-1:0] match_num;

    assign s_axi4s_tready = m_axi4s_tready || !m_axi4s_tvalid;
    assign adv            = s_axi4s_tready;

    // Palette lookup on the incoming pixel; scanning downward lets the lowest matching index win.
    always_comb begin
        match_num = NO_MATCH;
        for (int i = 9; i >= 0; i--) begin
`ifdef VIDEO_MNIST_COLOR_DECODE_TOLERANCE_EN
            if (pal_hit(s_axi4s_tdata[23:0], i, param_tol)) match_num = TNUMBER_WIDTH'(i);
`else
            if (pal_hit(s_axi4s_tdata[23:0], i)) match_num = TNUMBER_WIDTH'(i);
`endif
        end
    end

    // A beat opens a line after a tlast, when it carries tuser, or when it is the first since reset.
    assign line_start = !seen_q || prev_last_q || (|user0_q);

    // Next-state for both stages and the run counter; everything holds while stalled.
    always_comb begin
        vld0_d      = vld0_q;
        user0_d     = user0_q;
        last0_d     = last0_q;
        data0_d     = data0_q;
        num0_d      = num0_q;
        vld1_d      = vld1_q;
        user1_d     = user1_q;
        last1_d     = last1_q;
        data1_d     = data1_q;
        num1_d      = num1_q;
        cnt1_d      = cnt1_q;
        last_num_d  = last_num_q;
        run_cnt_d   = run_cnt_q;
        prev_last_d = prev_last_q;
        seen_d      = seen_q;

        if (adv) begin
            vld0_d  = s_axi4s_tvalid;
            user0_d = s_axi4s_tuser;
            last0_d = s_axi4s_tlast;
            data0_d = s_axi4s_tdata;
            num0_d  = match_num;

            // Bubbles must not disturb the run state.
            if (vld0_q) begin
                if (num0_q == NO_MATCH) begin
                    run_cnt_d = '0;
                end else if (line_start) begin
                    run_cnt_d = CNT_ONE;
                end else if (num0_q == last_num_q) begin
                    run_cnt_d = (run_cnt_q == CNT_MAX) ? CNT_MAX : run_cnt_q + CNT_ONE;
                end else begin
                    run_cnt_d = CNT_ONE;
                end
                last_num_d  = num0_q;
                prev_last_d = last0_q;
                seen_d      = 1'b1;
            end

            vld1_d  = vld0_q;
            user1_d = user0_q;
            last1_d = last0_q;
            data1_d = data0_q;
            num1_d  = num0_q;
            cnt1_d  = run_cnt_d;
        end
    end

    // Pipeline and run-state registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            vld0_q      <= 1'b0;
            user0_q     <= '0;
            last0_q     <= 1'b0;
            data0_q     <= '0;
            num0_q      <= '0;
            vld1_q      <= 1'b0;
            user1_q     <= '0;
            last1_q     <= 1'b0;
            data1_q     <= '0;
            num1_q      <= '0;
            cnt1_q      <= '0;
            last_num_q  <= NO_MATCH;
            run_cnt_q   <= '0;
            prev_last_q <= 1'b0;
            seen_q      <= 1'b0;
        end else begin
            vld0_q      <= vld0_d;
            user0_q     <= user0_d;
            last0_q     <= last0_d;
            data0_q     <= data0_d;
            num0_q      <= num0_d;
            vld1_q      <= vld1_d;
            user1_q     <= user1_d;
            last1_q     <= last1_d;
            data1_q     <= data1_d;
            num1_q      <= num1_d;
            cnt1_q      <= cnt1_d;
            last_num_q  <= last_num_d;
            run_cnt_q   <= run_cnt_d;
            prev_last_q <= prev_last_d;
            seen_q      <= seen_d;
        end
    end

    assign m_axi4s_tvalid  = vld1_q;
    assign m_axi4s_tuser   = user1_q;
    assign m_axi4s_tlast   = last1_q;
    assign m_axi4s_tdata   = data1_q;
    assign m_axi4s_tnumber = num1_q;
    assign m_axi4s_tcount  = cnt1_q;

endmodule

// File: tb/tb_video_mnist_color_decode.sv
// Directed-vector bench for video_mnist_color_decode with a queue scoreboard.
// Driver pushes the hand-computed expected beat; a negedge monitor pops on each output handshake.
// Also checks reset state, first-beat latency and output hold under m_axi4s_tready stall.
module tb_video_mnist_color_decode;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  param_tol = 8'd8;
    logic [0:0]  s_tuser = '0;
    logic        s_tlast = 1'b0;
    logic [23:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [0:0]  m_tuser;
    logic        m_tlast;
    logic [23:0] m_tdata;
    logic [3:0]  m_tnumber;
    logic [3:0]  m_tcount;
    logic        m_tvalid;
    logic        m_tready = 1'b1;

    typedef struct packed {
        logic [3:0]  num;
        logic [3:0]  cnt;
        logic [23:0] dat;
        logic        last;
        logic        user;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    bit    lat_pending = 1'b0;

    video_mnist_color_decode #(
        .TUSER_WIDTH(1), .TDATA_WIDTH(24), .TNUMBER_WIDTH(4), .TCOUNT_WIDTH(4)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .param_tol(param_tol),
        .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
        .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
        .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tdata(m_tdata),
        .m_axi4s_tnumber(m_tnumber), .m_axi4s_tcount(m_tcount),
        .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic beat_t cur_out();
        beat_t b;
        b.num  = m_tnumber;
        b.cnt  = m_tcount;
        b.dat  = m_tdata;
        b.last = m_tlast;
        b.user = m_tuser[0];
        return b;
    endfunction

    // Monitor: a handshake happens at the next posedge, so compare now while outputs are stable.
    always @(negedge aclk) begin
        if (aresetn && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got %0h, expected no output", cur_out());
            end else begin
                chk("beat", cur_out(), exp_q.pop_front());
            end
            if (lat_pending) begin
                chk("first_latency", cyc + 1 - acc_cyc, 2);
                lat_pending = 1'b0;
            end
        end
    end

    task automatic send(input logic [23:0] d, input bit last, input bit user,
                        input logic [3:0] en, input logic [3:0] ec, input bit track);
        beat_t b;
        int t;
        b.num = en; b.cnt = ec; b.dat = d; b.last = last; b.user = user;
        exp_q.push_back(b);
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
        s_tvalid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!s_tready && t < 200) begin
            t++;
            @(negedge aclk);
        end
        if (!s_tready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: s_tready stuck at 0 for pixel %06h", d);
        end
        @(posedge aclk);
        #1;
        if (track) begin
            acc_cyc     = cyc;
            lat_pending = 1'b1;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_tvalid) && t < 500) begin
            @(posedge aclk);
            #1;
            t++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_outputs", cur_out(), 0);
        chk("rst_s_tready", s_tready, 1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        do_reset();

        // Short line: run of red then black; first output two cycles after first accept.
        send(24'hFF0000, 0, 0, 2, 1, 1);
        send(24'hFF0000, 0, 0, 2, 2, 0);
        send(24'hFF0000, 0, 0, 2, 3, 0);
        send(24'h000000, 1, 0, 0, 1, 0);

        // Long grey run saturates at 15.
        for (int i = 1; i <= 20; i++)
            send(24'h808080, i == 20, 0, 8, (i > 15) ? 4'd15 : 4'(i), 0);

        // No-match pixel, then white.
        send(24'h123456, 0, 0, 15, 0, 0);
        send(24'hFFFFFF, 1, 0, 9, 1, 0);

        // Same colour across a line boundary restarts at 1.
        send(24'h0000FF, 0, 0, 6, 1, 0);
        send(24'h0000FF, 1, 0, 6, 2, 0);
        send(24'h0000FF, 0, 0, 6, 1, 0);
        send(24'h0000FF, 1, 0, 6, 2, 0);

        // tuser+tlast together, then a mid-line tuser.
        send(24'hFFFF00, 1, 1, 4, 1, 0);
        send(24'hFFFF00, 0, 0, 4, 1, 0);
        send(24'hFFFF00, 1, 0, 4, 2, 0);
        send(24'h800000, 0, 0, 1, 1, 0);
        send(24'h800000, 0, 1, 1, 1, 0);
        send(24'h800000, 1, 0, 1, 2, 0);

        // Gapped run with an output stall in the middle.
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    send(24'h800080, i == 8, 0, 7, 4'(i), 0);
                    if (i % 2 == 1) idle(2);
                end
                send(24'hFFB74C, 0, 0, 3, 1, 0);
                send(24'hFFB74C, 1, 0, 3, 2, 0);
            end
            begin
                beat_t snap;
                int t;
                t = 0;
                idle(3);
                while (!m_tvalid && t < 100) begin
                    idle(1);
                    t++;
                end
                m_tready = 1'b0;
                @(negedge aclk);
                snap = cur_out();
                for (int i = 0; i < 5; i++) begin
                    @(negedge aclk);
                    chk("stall_s_tready", s_tready, 0);
                    chk("stall_m_tvalid", m_tvalid, 1);
                    chk("stall_hold", cur_out(), snap);
                end
                @(posedge aclk);
                #1;
                m_tready = 1'b1;
            end
        join

        // Near-red pixel: tolerance build matches index 2, exact build does not.
`ifdef VIDEO_MNIST_COLOR_DECODE_TOLERANCE_EN
        send(24'hF80403, 0, 0, 2, 1, 0);
`else
        send(24'hF80403, 0, 0, 15, 0, 0);
`endif
        send(24'hF00000, 1, 0, 15, 0, 0);
        drain();

        // Reset in the middle of a line discards the partial run.
        send(24'h808080, 0, 0, 8, 1, 0);
        send(24'h808080, 0, 0, 8, 2, 0);
        send(24'h808080, 0, 0, 8, 3, 0);
        drain();
        do_reset();
        send(24'h808080, 0, 0, 8, 1, 0);
        send(24'h808080, 1, 0, 8, 2, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
